// File: rtl/game_pkg.sv
// Shared types and constants for the tile-matching game score keeper:
// game-phase enum, mode digits and output widths.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PLAY = 3'd1,
        WIN  = 3'd2,
        LOSE = 3'd3,
        QUIT = 3'd4
    } state_t;

    localparam logic [3:0] DIG_IDLE = 4'hF;
    localparam logic [3:0] DIG_PLAY = 4'h1;
    localparam logic [3:0] DIG_WIN  = 4'h2;
    localparam logic [3:0] DIG_LOSE = 4'h3;
    localparam logic [3:0] DIG_QUIT = 4'h4;

    localparam int SCORE_W = 6;
    localparam int LED_W   = 10;

    // Bit i of the result is set iff i < n.
    function automatic logic [LED_W-1:0] therm(input logic [3:0] n);
        logic [LED_W-1:0] t;
        for (int i = 0; i < LED_W; i++) begin
            t[i] = (i < int'(n));
        end
        return t;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge pulse generator; the history flop resets to RESET_VAL so a
// level already high when reset releases does not produce a pulse.
module edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= RESET_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d && !d_q;

endmodule

// File: rtl/score_keeper.sv
// Game-phase FSM, score, lives and LED blink source that feeds the display
// block; consumes match results from the board logic.
module score_keeper #(
    parameter int NUM_PAIRS        = 16,
    parameter int POINTS_PER_MATCH = 2,
    parameter int MAX_LIVES        = 10,
    parameter int BLINK_CYCLES     = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       quit_req,
    input  logic       match_valid,
    input  logic       match_hit,
    output logic       match_ready,
    output logic       userquit,
    output logic       ingameOn,
    output logic       gameOver,
    output logic [3:0] hex0hldr,
    output logic [3:0] hex4hldr,
    output logic [3:0] hex5hldr,
    output logic [9:0] ledrhldr
);

    import game_pkg::*;

    localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(BLINK_CYCLES - 1);
    localparam logic [SCORE_W:0]   SCORE_CAP = (SCORE_W+1)'(32);
    localparam logic [SCORE_W:0]   SCORE_INC = (SCORE_W+1)'(POINTS_PER_MATCH);
    localparam logic [5:0]         PAIRS_WIN = 6'(NUM_PAIRS);
    localparam logic [3:0]         LIVES_INI = 4'(MAX_LIVES);

    state_t               state, state_nxt;
    logic [SCORE_W-1:0]   score, score_nxt;
    logic [4:0]           pairs, pairs_nxt;
    logic [3:0]           lives, lives_nxt;
    logic [CNT_W-1:0]     blink_cnt, blink_cnt_nxt;
    logic                 blink_ph, blink_ph_nxt;
    logic                 start_edge;
    logic                 xfer;
    logic [SCORE_W:0]     score_sum;
    logic [5:0]           pairs_inc;

    edge_detect #(.RESET_VAL(1'b1)) u_start_edge (
        .clk   (clk),
        .reset (reset),
        .d     (start),
        .pulse (start_edge)
    );

    // Handshake: a match result transfers on a clock edge where match_valid
    // and match_ready are both high; match_ready is high only in PLAY with no
    // quit request, and match_hit is ignored unless match_valid is high.
    assign match_ready = (state == PLAY) && !quit_req;
    assign xfer        = match_valid && match_ready;
    assign score_sum   = {1'b0, score} + SCORE_INC;
    assign pairs_inc   = {1'b0, pairs} + 6'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            score     <= '0;
            pairs     <= '0;
            lives     <= LIVES_INI;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            state     <= state_nxt;
            score     <= score_nxt;
            pairs     <= pairs_nxt;
            lives     <= lives_nxt;
            blink_cnt <= blink_cnt_nxt;
            blink_ph  <= blink_ph_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        score_nxt     = score;
        pairs_nxt     = pairs;
        lives_nxt     = lives;
        blink_cnt_nxt = blink_cnt;
        blink_ph_nxt  = blink_ph;
        case (state)
            IDLE, WIN, LOSE, QUIT: begin
                if (start_edge) begin
                    state_nxt     = PLAY;
                    score_nxt     = '0;
                    pairs_nxt     = '0;
                    lives_nxt     = LIVES_INI;
                    blink_cnt_nxt = '0;
                    blink_ph_nxt  = 1'b0;
                end else if (state == WIN) begin
                    if (blink_cnt == CNT_LAST) begin
                        blink_cnt_nxt = '0;
                        blink_ph_nxt  = !blink_ph;
                    end else begin
                        blink_cnt_nxt = blink_cnt + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (quit_req) begin
                    state_nxt = QUIT;
                end else if (xfer) begin
                    if (match_hit) begin
                        // Score saturates rather than wrapping into the upper digit.
                        score_nxt = (score_sum > SCORE_CAP) ? SCORE_CAP[SCORE_W-1:0]
                                                            : score_sum[SCORE_W-1:0];
                        pairs_nxt = pairs_inc[4:0];
                        if (pairs_inc == PAIRS_WIN) begin
                            state_nxt     = WIN;
                            blink_cnt_nxt = '0;
                            blink_ph_nxt  = 1'b1;
                        end
                    end else if (lives <= 4'd1) begin
                        lives_nxt = '0;
                        state_nxt = LOSE;
                    end else begin
                        lives_nxt = lives - 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        userquit = (state == QUIT);
        ingameOn = (state == PLAY);
        gameOver = (state == WIN) || (state == LOSE);
        hex4hldr = score[3:0];
        hex5hldr = {2'b00, score[5:4]};
        hex0hldr = DIG_IDLE;
        ledrhldr = '0;
        case (state)
            PLAY: begin
                hex0hldr = DIG_PLAY;
                ledrhldr = therm(lives);
            end
            QUIT: begin
                hex0hldr = DIG_QUIT;
                ledrhldr = therm(lives);
            end
            WIN: begin
                hex0hldr = DIG_WIN;
                ledrhldr = {LED_W{blink_ph}};
            end
            LOSE: hex0hldr = DIG_LOSE;
            default: begin
                hex0hldr = DIG_IDLE;
                ledrhldr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a vector table for the opening sequence,
// then hand-written win, lose, quit and async-reset sequences.
module tb_score_keeper;

    typedef struct {
        logic       start;
        logic       quit;
        logic       mv;
        logic       mh;
        logic       rdy;
        logic       uq;
        logic       ig;
        logic       go;
        logic [3:0] h0;
        logic [3:0] h4;
        logic [3:0] h5;
        logic [9:0] led;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       quit_req;
    logic       match_valid;
    logic       match_hit;
    logic       match_ready;
    logic       userquit;
    logic       ingameOn;
    logic       gameOver;
    logic [3:0] hex0hldr;
    logic [3:0] hex4hldr;
    logic [3:0] hex5hldr;
    logic [9:0] ledrhldr;

    int errors = 0;
    int checks = 0;

    score_keeper #(
        .NUM_PAIRS        (16),
        .POINTS_PER_MATCH (2),
        .MAX_LIVES        (10),
        .BLINK_CYCLES     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .quit_req    (quit_req),
        .match_valid (match_valid),
        .match_hit   (match_hit),
        .match_ready (match_ready),
        .userquit    (userquit),
        .ingameOn    (ingameOn),
        .gameOver    (gameOver),
        .hex0hldr    (hex0hldr),
        .hex4hldr    (hex4hldr),
        .hex5hldr    (hex5hldr),
        .ledrhldr    (ledrhldr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input vec_t v);
        chk({tag, " userquit"}, 32'(userquit), 32'(v.uq));
        chk({tag, " ingameOn"}, 32'(ingameOn), 32'(v.ig));
        chk({tag, " gameOver"}, 32'(gameOver), 32'(v.go));
        chk({tag, " hex0"},     32'(hex0hldr), 32'(v.h0));
        chk({tag, " hex4"},     32'(hex4hldr), 32'(v.h4));
        chk({tag, " hex5"},     32'(hex5hldr), 32'(v.h5));
        chk({tag, " ledr"},     32'(ledrhldr), 32'(v.led));
    endtask

    // Drive inputs at the falling edge, check match_ready before the rising
    // edge, then check the registered outputs just after it.
    task automatic drive_cycle(input string tag, input vec_t v);
        @(negedge clk);
        start       = v.start;
        quit_req    = v.quit;
        match_valid = v.mv;
        match_hit   = v.mh;
        #1;
        chk({tag, " match_ready"}, 32'(match_ready), 32'(v.rdy));
        @(posedge clk);
        #1;
        chk_outputs(tag, v);
    endtask

    function automatic vec_t mk(input logic s, input logic q, input logic mv, input logic mh,
                                input logic rdy, input logic uq, input logic ig, input logic go,
                                input logic [3:0] h0, input logic [5:0] sc, input logic [9:0] led);
        vec_t v;
        v.start = s;  v.quit = q;  v.mv = mv;  v.mh = mh;
        v.rdy = rdy;  v.uq = uq;  v.ig = ig;  v.go = go;
        v.h0 = h0;
        v.h4 = sc[3:0];
        v.h5 = {2'b00, sc[5:4]};
        v.led = led;
        return v;
    endfunction

    vec_t tbl[16];
    vec_t v;
    vec_t rst_v;

    initial begin
        // start, quit, mv, mh | ready, userquit, ingame, gameover, hex0, score, led
        for (int i = 0; i < 5; i++) tbl[i] = mk(1,0,0,0, 0,0,0,0, 4'hF, 0, 10'h000);
        tbl[5]  = mk(0,0,1,1, 0,0,0,0, 4'hF, 0, 10'h000);
        tbl[6]  = mk(1,0,0,0, 0,0,1,0, 4'h1, 0, 10'h3FF);
        tbl[7]  = mk(0,0,1,1, 1,0,1,0, 4'h1, 2, 10'h3FF);
        tbl[8]  = mk(0,0,1,1, 1,0,1,0, 4'h1, 4, 10'h3FF);
        tbl[9]  = mk(0,0,1,1, 1,0,1,0, 4'h1, 6, 10'h3FF);
        tbl[10] = mk(0,0,1,0, 1,0,1,0, 4'h1, 6, 10'h1FF);
        tbl[11] = mk(1,0,0,0, 1,0,1,0, 4'h1, 6, 10'h1FF);
        tbl[12] = mk(0,1,1,1, 0,1,0,0, 4'h4, 6, 10'h1FF);
        tbl[13] = mk(0,0,1,1, 0,1,0,0, 4'h4, 6, 10'h1FF);
        tbl[14] = mk(1,0,0,0, 0,0,1,0, 4'h1, 0, 10'h3FF);
        tbl[15] = mk(0,0,0,0, 1,0,1,0, 4'h1, 0, 10'h3FF);
        rst_v   = mk(0,0,0,0, 0,0,0,0, 4'hF, 0, 10'h000);

        reset = 1'b1;
        start = 1'b1;
        quit_req = 1'b0;
        match_valid = 1'b0;
        match_hit = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs("reset", rst_v);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive_cycle($sformatf("tbl%0d", i), tbl[i]);
        end

        // 16 hits to win; score model is 2 per hit capped at 32.
        for (int k = 1; k <= 16; k++) begin
            int sc;
            sc = (2 * k > 32) ? 32 : 2 * k;
            if (k < 16) v = mk(0,0,1,1, 1,0,1,0, 4'h1, 6'(sc), 10'h3FF);
            else        v = mk(0,0,1,1, 1,0,0,1, 4'h2, 6'(sc), 10'h3FF);
            drive_cycle($sformatf("hit%0d", k), v);
        end

        // Held match_valid in WIN is dropped; LEDs blink with period 2*4 cycles.
        for (int e = 1; e <= 13; e++) begin
            logic ph;
            ph = ((e / 4) % 2) == 0;
            v = mk(0,0,1,1, 0,0,0,1, 4'h2, 6'd32, {10{ph}});
            drive_cycle($sformatf("blink%0d", e), v);
        end

        v = mk(1,0,0,0, 0,0,1,0, 4'h1, 0, 10'h3FF);
        drive_cycle("restart_win", v);

        for (int k = 1; k <= 10; k++) begin
            if (k < 10) v = mk(0,0,1,0, 1,0,1,0, 4'h1, 0, 10'h3FF >> k);
            else        v = mk(0,0,1,0, 1,0,0,1, 4'h3, 0, 10'h000);
            drive_cycle($sformatf("miss%0d", k), v);
        end

        v = mk(0,0,1,1, 0,0,0,1, 4'h3, 0, 10'h000);
        drive_cycle("lose_hold", v);
        v = mk(1,0,0,0, 0,0,1,0, 4'h1, 0, 10'h3FF);
        drive_cycle("restart_lose", v);

        for (int k = 1; k <= 7; k++) begin
            v = mk(0,0,1,1, 1,0,1,0, 4'h1, 6'(2 * k), 10'h3FF);
            drive_cycle($sformatf("pre_hit%0d", k), v);
        end
        for (int k = 1; k <= 3; k++) begin
            v = mk(0,0,1,0, 1,0,1,0, 4'h1, 6'd14, 10'h3FF >> k);
            drive_cycle($sformatf("pre_miss%0d", k), v);
        end

        // Reset between clock edges must clear outputs without a clock.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_outputs("async_reset", rst_v);
        chk("async_reset match_ready", 32'(match_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        v = mk(0,0,0,0, 0,0,0,0, 4'hF, 0, 10'h000);
        drive_cycle("post_reset_idle", v);
        v = mk(1,0,0,0, 0,0,1,0, 4'h1, 0, 10'h3FF);
        drive_cycle("post_reset_start", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
